// File: rtl/fft_bfly_feeder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_pkg : constants, complex word type and FSM encoding for the FFT feeder.
// Rev 1.0
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int BITS   = 16;
  localparam int FRAC   = 7;
  localparam int LOG2N  = 5;
  localparam int N      = 1 << LOG2N;
  localparam int HALF_N = N / 2;

  // Packed {imag, real}
  typedef logic [2*BITS-1:0] cplx_t;

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  function automatic logic [BITS-1:0] cplx_re(input cplx_t w);
    return w[BITS-1:0];
  endfunction

  function automatic logic [BITS-1:0] cplx_im(input cplx_t w);
    return w[2*BITS-1:BITS];
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_bfly_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_bfly_feeder_if : sample input stream and butterfly operand output stream.
// Rev 1.0
// ---------------------------------------------------------------------------
interface fft_bfly_feeder_if;
  import fft_pkg::*;

  cplx_t            in_data;
  logic             in_valid;
  logic             in_ready;
  logic [LOG2N-1:0] stage;
  cplx_t            out_in0;
  cplx_t            out_in1;
  cplx_t            out_twiddle;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             frame_done;

  // master is the feeder; slave is the surrounding producer/consumer
  modport master (
    input  in_data, in_valid, stage, out_ready,
    output in_ready, out_in0, out_in1, out_twiddle, out_valid, out_last, frame_done
  );

  modport slave (
    output in_data, in_valid, stage, out_ready,
    input  in_ready, out_in0, out_in1, out_twiddle, out_valid, out_last, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/fft_twiddle_rom.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_twiddle_rom : combinational W32^t, packed {imag, real}, scaled by 2^FRAC.
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_twiddle_rom #(
  parameter int BITS = fft_pkg::BITS,
  parameter int FRAC = fft_pkg::FRAC
) (
  input  logic [3:0]        i_t,
  output logic [2*BITS-1:0] o_w
);

  // cos(pi*m/16) for m = 0..8 in Q16; other angles follow by symmetry
  function automatic longint cos_q16(input int m);
    case (m)
      0:       return 64'sd65536;
      1:       return 64'sd64277;
      2:       return 64'sd60547;
      3:       return 64'sd54491;
      4:       return 64'sd46341;
      5:       return 64'sd36410;
      6:       return 64'sd25080;
      7:       return 64'sd12785;
      default: return 64'sd0;
    endcase
  endfunction

  // Round half away from zero: round the magnitude, then apply the sign
  function automatic logic [BITS-1:0] scaled(input int m, input logic neg);
    longint mag;
    mag = ((cos_q16(m) <<< FRAC) + 64'sd32768) >>> 16;
    return BITS'(neg ? -mag : mag);
  endfunction

  logic [BITS-1:0] w_re;
  logic [BITS-1:0] w_im;

  always_comb begin
    w_re = '0;
    w_im = '0;
    if (i_t <= 4'd8) begin
      w_re = scaled(int'(i_t), 1'b0);
      w_im = scaled(8 - int'(i_t), 1'b1);
    end else begin
      w_re = scaled(16 - int'(i_t), 1'b1);
      w_im = scaled(int'(i_t) - 8, 1'b1);
    end
  end

  assign o_w = {w_im, w_re};

endmodule
`default_nettype wire

// File: rtl/fft_bfly_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fft_bfly_feeder : buffers a 32-point frame and issues DIT butterfly operand
// triples for one stage. Define BITREV_LOAD_EN to bit-reverse load addresses.
// Rev 1.0
// ---------------------------------------------------------------------------
module fft_bfly_feeder
  import fft_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  fft_bfly_feeder_if.master  bus
);

  state_t           r_state;
  logic [LOG2N-1:0] r_wr_cnt;
  logic [LOG2N-1:0] r_k;
  logic [2:0]       r_stg;
  cplx_t            r_mem [N];
  cplx_t            r_in0;
  cplx_t            r_in1;
  cplx_t            r_tw;
  logic             r_valid;
  logic             r_last;
  logic             r_done;

  logic [LOG2N-1:0] w_wa;
  logic [LOG2N-1:0] w_span;
  logic [LOG2N-1:0] w_pos;
  logic [LOG2N-1:0] w_i0;
  logic [LOG2N-1:0] w_i1;
  logic [3:0]       w_t;
  logic [2:0]       w_stg_clamp;
  cplx_t            w_rom;
  logic             w_accept_in;
  logic             w_fire;
  logic             w_load;

`ifdef BITREV_LOAD_EN
  assign w_wa = bitrev(r_wr_cnt);
`else
  assign w_wa = r_wr_cnt;
`endif

  assign w_accept_in = bus.in_valid && (r_state == LOAD);
  assign w_fire      = r_valid && bus.out_ready;
  // r_k reaching HALF_N means every pair of the frame has been loaded
  assign w_load      = (r_state == ISSUE) && (r_k < LOG2N'(HALF_N)) &&
                       (!r_valid || bus.out_ready);

  assign w_stg_clamp = (bus.stage > LOG2N'(LOG2N-1)) ? 3'(LOG2N-1) : bus.stage[2:0];

  assign w_span = LOG2N'(1) << r_stg;
  assign w_pos  = r_k & (w_span - LOG2N'(1));
  assign w_i0   = ((r_k >> r_stg) << (r_stg + 3'd1)) + w_pos;
  assign w_i1   = w_i0 + w_span;
  assign w_t    = w_pos[3:0] << (3'(LOG2N-1) - r_stg);

  fft_twiddle_rom #(
    .BITS (BITS),
    .FRAC (FRAC)
  ) u_rom (
    .i_t (w_t),
    .o_w (w_rom)
  );

  // Frame storage has no reset; a fresh load always overwrites it
  always_ff @(posedge clk) begin
    if (w_accept_in) r_mem[w_wa] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= LOAD;
      r_wr_cnt <= '0;
      r_k      <= '0;
      r_stg    <= '0;
      r_in0    <= '0;
      r_in1    <= '0;
      r_tw     <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_accept_in) begin
            r_wr_cnt <= r_wr_cnt + LOG2N'(1);
            if (r_wr_cnt == LOG2N'(N-1)) begin
              r_stg   <= w_stg_clamp;
              r_k     <= '0;
              r_state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (w_load) begin
            r_in0   <= r_mem[w_i0];
            r_in1   <= r_mem[w_i1];
            r_tw    <= w_rom;
            r_valid <= 1'b1;
            r_last  <= (r_k == LOG2N'(HALF_N-1));
            r_k     <= r_k + LOG2N'(1);
          end else if (w_fire && r_last) begin
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_done   <= 1'b1;
            r_wr_cnt <= '0;
            r_state  <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == LOAD);
  assign bus.out_in0     = r_in0;
  assign bus.out_in1     = r_in1;
  assign bus.out_twiddle = r_tw;
  assign bus.out_valid   = r_valid;
  assign bus.out_last    = r_last;
  assign bus.frame_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_bfly_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fft_bfly_feeder : table-driven and scoreboard checks of the operand feeder.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fft_bfly_feeder;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fft_bfly_feeder_if bus();

  fft_bfly_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    cplx_t in0;
    cplx_t in1;
    cplx_t tw;
  } trip_t;

  typedef struct {
    int stage;
    int mode;   // 0 always ready, 1 random ready, 2 random ready + stage/in_valid noise
    int k;
    int i0;
    int i1;
    int t;
  } vec_t;

  trip_t sb[$];
  trip_t cap[16];
  cplx_t tw_tab[16];
  vec_t  vecs[12];
  int    n_tests = 0;
  int    n_fail  = 0;

  function automatic cplx_t sample(input int i);
    return {16'(32'h1000 + i), 16'(i * 32'h80)};
  endfunction

  // Content of storage word j after loading sample(c) at accept count c
  function automatic cplx_t mem_model(input int j);
`ifdef BITREV_LOAD_EN
    int r;
    r = 0;
    for (int b = 0; b < 5; b++) if (j[b]) r = r | (1 << (4 - b));
    return sample(r);
`else
    return sample(j);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({name, "_last"},  64'(bus.out_last), 64'd0);
    check({name, "_done"},  64'(bus.frame_done), 64'd0);
    check({name, "_in0"},   64'(bus.out_in0), 64'd0);
    check({name, "_in1"},   64'(bus.out_in1), 64'd0);
    check({name, "_tw"},    64'(bus.out_twiddle), 64'd0);
    check({name, "_inrdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Starts and ends on a falling edge
  task automatic load_frame(input int nsamp, input int stage_val);
    int guard;
    bus.stage = 5'(stage_val);
    for (int c = 0; c < nsamp; c++) begin
      bus.in_data  = sample(c);
      bus.in_valid = 1'b1;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard == 100) begin
        timeout("load_in_ready");
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_issue(input int stage_val, input int mode);
    int    s;
    int    span;
    int    got;
    int    cycles;
    bit    held;
    trip_t hv;
    s      = (stage_val > 4) ? 4 : stage_val;
    span   = 1 << s;
    got    = 0;
    cycles = 0;
    held   = 1'b0;
    sb.delete();
    for (int g = 0; g < 16 / span; g++) begin
      for (int j = 0; j < span; j++) begin
        trip_t e;
        e.in0 = mem_model(g * 2 * span + j);
        e.in1 = mem_model(g * 2 * span + j + span);
        e.tw  = tw_tab[j * (16 / span)];
        sb.push_back(e);
      end
    end
    while (got < 16 && cycles < 500) begin
      if (mode == 0) bus.out_ready = 1'b1;
      else           bus.out_ready = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        bus.stage    = 5'($urandom_range(0, 31));
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEAD_BEEF;
        check("in_ready_during_issue", 64'(bus.in_ready), 64'd0);
      end
      if (held) begin
        check("stall_valid", 64'(bus.out_valid), 64'd1);
        check("stall_in0", 64'(bus.out_in0), 64'(hv.in0));
        check("stall_in1", 64'(bus.out_in1), 64'(hv.in1));
        check("stall_tw",  64'(bus.out_twiddle), 64'(hv.tw));
        held = 1'b0;
      end
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          trip_t e;
          e = sb.pop_front();
          if (mode == 0 && got == 0) check("first_latency", 64'(cycles), 64'd1);
          check("sb_in0", 64'(bus.out_in0), 64'(e.in0));
          check("sb_in1", 64'(bus.out_in1), 64'(e.in1));
          check("sb_tw",  64'(bus.out_twiddle), 64'(e.tw));
          check("sb_last", 64'(bus.out_last), 64'(got == 15));
          cap[got].in0 = bus.out_in0;
          cap[got].in1 = bus.out_in1;
          cap[got].tw  = bus.out_twiddle;
          got++;
        end else begin
          held   = 1'b1;
          hv.in0 = bus.out_in0;
          hv.in1 = bus.out_in1;
          hv.tw  = bus.out_twiddle;
        end
      end
      @(negedge clk);
      cycles++;
    end
    bus.in_valid = 1'b0;
    if (got < 16) begin
      timeout("issue_transfers");
      return;
    end
    check("frame_done_pulse", 64'(bus.frame_done), 64'd1);
    check("valid_after_last", 64'(bus.out_valid), 64'd0);
    check("in_ready_after_last", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    check("frame_done_cleared", 64'(bus.frame_done), 64'd0);
  endtask

  initial begin
    int cur_stage;
    int cur_mode;
    int guard;

    tw_tab[0]  = 32'h0000_0080; tw_tab[1]  = 32'hFFE7_007E;
    tw_tab[2]  = 32'hFFCF_0076; tw_tab[3]  = 32'hFFB9_006A;
    tw_tab[4]  = 32'hFFA5_005B; tw_tab[5]  = 32'hFF96_0047;
    tw_tab[6]  = 32'hFF8A_0031; tw_tab[7]  = 32'hFF82_0019;
    tw_tab[8]  = 32'hFF80_0000; tw_tab[9]  = 32'hFF82_FFE7;
    tw_tab[10] = 32'hFF8A_FFCF; tw_tab[11] = 32'hFF96_FFB9;
    tw_tab[12] = 32'hFFA5_FFA5; tw_tab[13] = 32'hFFB9_FF96;
    tw_tab[14] = 32'hFFCF_FF8A; tw_tab[15] = 32'hFFE7_FF82;

    vecs[0]  = '{0, 0,  0,  0,  1,  0};
    vecs[1]  = '{0, 0, 15, 30, 31,  0};
    vecs[2]  = '{4, 0,  4,  4, 20,  4};
    vecs[3]  = '{4, 0,  8,  8, 24,  8};
    vecs[4]  = '{2, 1,  2,  2,  6,  8};
    vecs[5]  = '{2, 1,  4,  8, 12,  0};
    vecs[6]  = '{2, 1, 15, 27, 31, 12};
    vecs[7]  = '{1, 0,  3,  5,  7,  8};
    vecs[8]  = '{3, 0,  9, 17, 25,  2};
    vecs[9]  = '{3, 0,  0,  0,  8,  0};
    vecs[10] = '{7, 2, 15, 15, 31, 15};
    vecs[11] = '{7, 2,  0,  0, 16,  0};

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.stage     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("in_reset");
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("after_release");

    cur_stage = -1;
    cur_mode  = -1;
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].stage != cur_stage || vecs[v].mode != cur_mode) begin
        cur_stage = vecs[v].stage;
        cur_mode  = vecs[v].mode;
        load_frame(32, cur_stage);
        run_issue(cur_stage, cur_mode);
      end
      check($sformatf("vec%0d_in0", v), 64'(cap[vecs[v].k].in0), 64'(mem_model(vecs[v].i0)));
      check($sformatf("vec%0d_in1", v), 64'(cap[vecs[v].k].in1), 64'(mem_model(vecs[v].i1)));
      check($sformatf("vec%0d_tw", v),  64'(cap[vecs[v].k].tw),  64'(tw_tab[vecs[v].t]));
    end

`ifdef BITREV_LOAD_EN
    load_frame(32, 0);
    run_issue(0, 0);
    check("bitrev_p0_in0", 64'(cap[0].in0), 64'(sample(0)));
    check("bitrev_p0_in1", 64'(cap[0].in1), 64'(sample(16)));
    check("bitrev_p1_in0", 64'(cap[1].in0), 64'(sample(8)));
    check("bitrev_p1_in1", 64'(cap[1].in1), 64'(sample(24)));
`endif

    // Reset while a pair is stalled in ISSUE
    load_frame(32, 0);
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("stalled_valid_before_reset", 64'(bus.out_valid), 64'd1);
    #2 reset = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Partial frame discarded by reset; a full 32 samples are required afterwards
    load_frame(10, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    load_frame(31, 3);
    check("in_ready_before_32nd", 64'(bus.in_ready), 64'd1);
    check("no_valid_before_32nd", 64'(bus.out_valid), 64'd0);
    bus.in_data  = sample(31);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_after_32nd", 64'(bus.in_ready), 64'd0);
    run_issue(3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
